// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI transmit scheduler.
// Holds the default block sizes, the host opcode values, the FSM state
// type and a small helper that recognises "pin to source k" opcodes.
package spi_sched_pkg;

  localparam int N_SRC_DEF   = 4;
  localparam int DATA_W_DEF  = 40;
  localparam int FRAME_W_DEF = 88;
  localparam int IDX_W       = 3;   // enough for up to 8 sources

  localparam logic [7:0] OP_RR       = 8'h00;
  localparam logic [7:0] OP_FIX_BASE = 8'h10;
  localparam logic [7:0] OP_WRITE    = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DECODE = 2'd2
  } state_t;

  // True when op is OP_FIX_BASE+k with k addressing an existing source.
  function automatic logic fix_op_ok(input logic [7:0] op, input int n_src);
    logic [7:0] k;
    k = op - OP_FIX_BASE;
    return (op >= OP_FIX_BASE) && ({24'd0, k} < n_src);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin next-fresh finder.
// Searches last_sent+1 .. last_sent+N_SRC (mod N_SRC) and reports the first
// source whose fresh bit is set.
// Ports:
//   fresh     in  N_SRC  per-source "unsent data" flags
//   last_sent in  3      index of the source sent in the previous frame
//   found     out 1      at least one source is fresh
//   index     out 3      first fresh source after last_sent (last_sent if none)
module rr_pick
  import spi_sched_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic [N_SRC-1:0] fresh,
  input  logic [IDX_W-1:0] last_sent,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    index = last_sent;
    for (int k = 1; k <= N_SRC; k++) begin
      c = int'(last_sent) + k;
      if (c >= N_SRC) c = c - N_SRC;
      // Inner loop keeps every fresh[] select a constant index.
      for (int j = 0; j < N_SRC; j++) begin
        if (!found && (j == c) && fresh[j]) begin
          found = 1'b1;
          index = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// SPI transmit scheduler.
// Captures sensor snapshots, chooses which one the SPI slave shifts out on
// MISO (round-robin over fresh data or a host-pinned source), and decodes
// the host command frame once slave select is released.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   ssel         raw SPI slave select (active low, asynchronous to clk)
//   rx_frame     last frame shifted in by the SPI slave, opcode in top byte
//   src_data     packed sensor results, slot i at [i*DATA_W +: DATA_W]
//   src_valid    per-source result-ready
//   src_ack      one-cycle pulse after a result is captured
//   tx_data      word for the SPI slave to load
//   tx_src       source index of tx_data
//   tx_fresh     tx_data has not yet been sent
//   cmd_valid    one-cycle pulse on a decoded write command
//   cmd_payload  payload of the last write command
//   mode_fixed   0 = round-robin, 1 = fixed source
//   err_cnt      saturating count of unknown opcodes
//
// state  | meaning
// IDLE   | no frame in progress; selection and tx_* track the snapshots
// ACTIVE | frame in progress; tx_* frozen, selected slot may not capture
// DECODE | frame finished; opcode in rx_frame is acted on (one cycle)
module spi_tx_scheduler
  import spi_sched_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ssel,
  input  logic [FRAME_W-1:0]      rx_frame,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ack,
  output logic [DATA_W-1:0]       tx_data,
  output logic [IDX_W-1:0]        tx_src,
  output logic                    tx_fresh,
  output logic                    cmd_valid,
  output logic [FRAME_W-9:0]      cmd_payload,
  output logic                    mode_fixed,
  output logic [7:0]              err_cnt
);

  // ---------------------------------------------------------------------
  // SSEL synchroniser and edge detection
  // ---------------------------------------------------------------------
  logic       ssel_s1, ssel_s2, ssel_d;
  logic [1:0] prime_cnt;
  logic       armed;
  logic       start, stop;

  // The reset value of the synchroniser is not a real observation of SSEL
  // being high. prime_cnt counts down until ssel_s2 holds a genuine sample,
  // and a start is only accepted once SSEL has truly been seen inactive.
  // This keeps a frame cut by reset from restarting on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssel_s1   <= 1'b1;
      ssel_s2   <= 1'b1;
      ssel_d    <= 1'b1;
      prime_cnt <= 2'd2;
      armed     <= 1'b0;
    end else begin
      ssel_s1 <= ssel;
      ssel_s2 <= ssel_s1;
      ssel_d  <= ssel_s2;
      if (prime_cnt != 2'd0) prime_cnt <= prime_cnt - 2'd1;
      if ((prime_cnt == 2'd0) && ssel_s2) armed <= 1'b1;
    end
  end

  assign start = armed & ssel_d & ~ssel_s2;
  assign stop  = ~ssel_d & ssel_s2;

  // ---------------------------------------------------------------------
  // Snapshot capture
  // ---------------------------------------------------------------------
  state_t                state;
  logic [IDX_W-1:0]      sel;
  logic [IDX_W-1:0]      last_sent;
  logic [IDX_W-1:0]      fixed_idx;
  logic                  start_ev;
  logic [DATA_W-1:0]     snap [N_SRC];
  logic [N_SRC-1:0]      fresh;
  logic [N_SRC-1:0]      blocked;
  logic [N_SRC-1:0]      cap;

  assign start_ev = start && (state == IDLE);

  // The selected slot is frozen from the start cycle until the frame has
  // been decoded; a held src_valid captures on the first free cycle.
  always_comb begin
    blocked = '0;
    cap     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      blocked[i] = (sel == IDX_W'(i)) && ((state != IDLE) || start_ev);
      cap[i]     = src_valid[i] & ~blocked[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh   <= '0;
      src_ack <= '0;
      for (int i = 0; i < N_SRC; i++) snap[i] <= '0;
    end else begin
      src_ack <= cap;
      for (int i = 0; i < N_SRC; i++) begin
        if (cap[i]) begin
          snap[i]  <= src_data[i*DATA_W +: DATA_W];
          fresh[i] <= 1'b1;
        end else if (start_ev && (sel == IDX_W'(i))) begin
          fresh[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Selection helpers
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] sel_data;
  logic              sel_fresh;
  logic              rr_found;
  logic [IDX_W-1:0]  rr_idx;

  always_comb begin
    sel_data  = '0;
    sel_fresh = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_data  = snap[i];
        sel_fresh = fresh[i];
      end
    end
  end

  rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .fresh     (fresh),
    .last_sent (last_sent),
    .found     (rr_found),
    .index     (rr_idx)
  );

  logic [7:0] opcode;
  assign opcode = rx_frame[FRAME_W-1 -: 8];

  // ---------------------------------------------------------------------
  // Frame FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      last_sent   <= IDX_W'(N_SRC - 1);
      fixed_idx   <= '0;
      mode_fixed  <= 1'b0;
      tx_data     <= '0;
      tx_src      <= '0;
      tx_fresh    <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_payload <= '0;
      err_cnt     <= '0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // tx_* and sel hold here and stay frozen for the whole frame.
            state     <= ACTIVE;
            last_sent <= sel;
          end else begin
            if (mode_fixed)    sel <= fixed_idx;
            else if (rr_found) sel <= rr_idx;
            tx_data  <= sel_data;
            tx_src   <= sel;
            tx_fresh <= sel_fresh;
          end
        end
        ACTIVE: begin
          if (stop) state <= DECODE;
        end
        DECODE: begin
          state <= IDLE;
          if (opcode == OP_RR) begin
            mode_fixed <= 1'b0;
          end else if (fix_op_ok(opcode, N_SRC)) begin
            mode_fixed <= 1'b1;
            fixed_idx  <= IDX_W'(opcode - OP_FIX_BASE);
          end else if (opcode == OP_WRITE) begin
            cmd_valid   <= 1'b1;
            cmd_payload <= rx_frame[FRAME_W-9:0];
          end else if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
